// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: bubble instruction, redirect bit indices and fetch state encoding.
package pipe_pkg;
  localparam logic [31:0] NOP_INSN = 32'hdc00_0000;

  localparam int JON_BR = 0;
  localparam int JON_J  = 1;
  localparam int JON_JR = 2;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_pc_sel.sv
// Combinational next-PC selection: prioritised redirect target, sequential pc+4,
// deferred (killed-beat) target, or hold.
module fetch_pc_sel
  import pipe_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [2:0]  jon210,
  input  logic [31:0] br_target,
  input  logic [31:0] j_target,
  input  logic [31:0] jr_target,
  input  logic [31:0] kill_target,
  input  logic        defer,
  input  logic        kill_done,
  input  logic        adv,
  output logic        redir,
  output logic [31:0] redir_tgt,
  output logic [31:0] pc_inc,
  output logic [31:0] pc_next
);
  assign redir  = |jon210;
  assign pc_inc = pc + 32'd4;

  always_comb begin
    redir_tgt = '0;
    if (jon210[JON_JR])      redir_tgt = jr_target;
    else if (jon210[JON_J])  redir_tgt = j_target;
    else if (jon210[JON_BR]) redir_tgt = br_target;
    redir_tgt[1:0] = 2'b00;
  end

  // A redirect during an unfinished handshake is deferred so imem_addr stays put.
  always_comb begin
    pc_next = pc;
    if (redir && !defer) pc_next = redir_tgt;
    else if (kill_done)  pc_next = kill_target;
    else if (adv)        pc_next = pc_inc;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the F/D register: single outstanding imem request,
// redirect/kill handling and a one-word skid for stalls. FETCH_PERF_EN adds perf counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = pipe_pkg::NOP_INSN
)(
  input  logic        clk,
  input  logic        rstd,
  input  logic        stall,
  input  logic [2:0]  jon210,
  input  logic [31:0] br_target,
  input  logic [31:0] j_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] ins_out,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles,
`endif
  output logic        valid_out
);
  import pipe_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, tgt_q, tgt_d, skid_q, skid_d;
  logic [31:0]  pc_out_q, pc_out_d, ins_q, ins_d;
  logic         kill_q, kill_d, req_q, req_d, vld_q, vld_d;
  logic         redir, defer, kill_done, adv;
  logic [31:0]  redir_tgt, pc_inc;

  fetch_pc_sel u_pc_sel (
    .pc          (pc_q),
    .jon210      (jon210),
    .br_target   (br_target),
    .j_target    (j_target),
    .jr_target   (jr_target),
    .kill_target (tgt_q),
    .defer       (defer),
    .kill_done   (kill_done),
    .adv         (adv),
    .redir       (redir),
    .redir_tgt   (redir_tgt),
    .pc_inc      (pc_inc),
    .pc_next     (pc_d)
  );

  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    tgt_d     = tgt_q;
    skid_d    = skid_q;
    req_d     = req_q;
    pc_out_d  = pc_out_q;
    ins_d     = ins_q;
    vld_d     = vld_q;
    defer     = req_q && !imem_ready;
    kill_done = 1'b0;
    adv       = 1'b0;
    if (redir) begin
      ins_d   = NOP_INSN;
      vld_d   = 1'b0;
      state_d = ST_FETCH;
      req_d   = 1'b1;
      kill_d  = (state_q == ST_FETCH) && defer;
      if ((state_q == ST_FETCH) && defer) tgt_d = redir_tgt;
    end else if (state_q == ST_HOLD) begin
      if (!stall) begin
        pc_out_d = pc_inc;
        ins_d    = skid_q;
        vld_d    = 1'b1;
        adv      = 1'b1;
        state_d  = ST_FETCH;
        req_d    = 1'b1;
      end
    end else begin
      req_d = 1'b1;
      if (kill_q) begin
        // The beat returning now belongs to the abandoned address.
        if (imem_ready) begin
          kill_done = 1'b1;
          kill_d    = 1'b0;
        end
        if (!stall) begin
          ins_d = NOP_INSN;
          vld_d = 1'b0;
        end
      end else if (req_q && imem_ready && stall) begin
        skid_d  = imem_rdata;
        state_d = ST_HOLD;
        req_d   = 1'b0;
      end else if (req_q && imem_ready) begin
        pc_out_d = pc_inc;
        ins_d    = imem_rdata;
        vld_d    = 1'b1;
        adv      = 1'b1;
      end else if (!stall) begin
        ins_d = NOP_INSN;
        vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q  <= ST_FETCH;
      pc_q     <= {RESET_PC[31:2], 2'b00};
      tgt_q    <= '0;
      skid_q   <= '0;
      kill_q   <= 1'b0;
      req_q    <= 1'b0;
      pc_out_q <= '0;
      ins_q    <= NOP_INSN;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      skid_q   <= skid_d;
      kill_q   <= kill_d;
      req_q    <= req_d;
      pc_out_q <= pc_out_d;
      ins_q    <= ins_d;
      vld_q    <= vld_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc_out    = pc_out_q;
  assign ins_out   = ins_q;
  assign valid_out = vld_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_f_q, perf_f_d, perf_b_q, perf_b_d;

  always_comb begin
    perf_f_d = perf_f_q + {31'd0, adv};
    perf_b_d = perf_b_q + {31'd0, (ins_q == NOP_INSN) && !stall};
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      perf_f_q <= '0;
      perf_b_q <= '0;
    end else begin
      perf_f_q <= perf_f_d;
      perf_b_q <= perf_b_d;
    end
  end

  assign perf_fetched = perf_f_q;
  assign perf_bubbles = perf_b_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural fetch model.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'hdc00_0000;

  logic        clk = 1'b0;
  logic        rstd = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  jon210 = 3'b000;
  logic [31:0] br_target = '0, j_target = '0, jr_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out, ins_out;
  logic        valid_out;
  logic [31:0] xmask = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory image: each word is its address scrambled by xmask.
  assign imem_rdata = imem_addr ^ xmask;

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INSN(NOP)) dut (
    .clk        (clk),
    .rstd       (rstd),
    .stall      (stall),
    .jon210     (jon210),
    .br_target  (br_target),
    .j_target   (j_target),
    .jr_target  (jr_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .pc_out     (pc_out),
    .ins_out    (ins_out),
    .valid_out  (valid_out)
  );

  // Behavioural model: what the decode side and memory must observe.
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_kill;
  logic [31:0] m_kill_tgt;
  logic [31:0] parked[$];
  logic [31:0] m_pc_out, m_ins;
  logic        m_vld;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ xmask;
  endfunction

  function automatic logic [31:0] pick(input logic [2:0] jon, input logic [31:0] br,
                                       input logic [31:0] j, input logic [31:0] jr);
    logic [31:0] t;
    if (jon[2])      t = jr;
    else if (jon[1]) t = j;
    else             t = br;
    return t & 32'hFFFF_FFFC;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req = 1'b0; m_addr = RST_PC; m_kill = 1'b0; m_kill_tgt = '0;
    parked.delete();
    m_pc_out = '0; m_ins = NOP; m_vld = 1'b0;
  endtask

  task automatic bubble(input logic st);
    if (!st) begin m_ins = NOP; m_vld = 1'b0; end
  endtask

  task automatic deliver(input logic [31:0] w);
    m_ins = w; m_pc_out = m_addr + 32'd4; m_vld = 1'b1; m_addr = m_addr + 32'd4;
  endtask

  task automatic model_step(input logic rdy, input logic st, input logic [2:0] jon,
                            input logic [31:0] br, input logic [31:0] j, input logic [31:0] jr);
    logic [31:0] t;
    t = pick(jon, br, j, jr);
    if (jon != 3'b000) begin
      m_ins = NOP; m_vld = 1'b0;
      if (parked.size() == 0 && m_req && !rdy) begin
        m_kill = 1'b1; m_kill_tgt = t;
      end else begin
        m_kill = 1'b0; m_addr = t;
      end
      parked.delete();
      m_req = 1'b1;
    end else if (parked.size() != 0) begin
      if (!st) begin
        deliver(parked.pop_front());
        m_req = 1'b1;
      end
    end else if (m_kill) begin
      if (rdy) begin m_kill = 1'b0; m_addr = m_kill_tgt; end
      bubble(st);
      m_req = 1'b1;
    end else if (m_req && rdy) begin
      if (st) begin parked.push_back(mem(m_addr)); m_req = 1'b0; end
      else deliver(mem(m_addr));
    end else begin
      bubble(st);
      m_req = 1'b1;
    end
  endtask

  task automatic compare_model();
    chk("imem_req", imem_req, m_req);
    if (m_req) chk("imem_addr", imem_addr, m_addr);
    chk("pc_out", pc_out, m_pc_out);
    chk("ins_out", ins_out, m_ins);
    chk("valid_out", valid_out, m_vld);
  endtask

  // Called at a negedge; returns at the following negedge after comparing.
  task automatic cycle(input logic rdy, input logic st, input logic [2:0] jon,
                       input logic [31:0] br, input logic [31:0] j, input logic [31:0] jr);
    imem_ready = rdy; stall = st; jon210 = jon;
    br_target = br; j_target = j; jr_target = jr;
    model_step(rdy, st, jon, br, j, jr);
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    rstd = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_ins", ins_out, NOP);
    chk("rst_vld", valid_out, 0);
    chk("rst_pcout", pc_out, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstd = 1'b1;
    compare_model();
  endtask

  initial begin
    logic rdy, st;
    logic [2:0] jon;
    logic [31:0] br, j, jr;

    @(negedge clk);
    do_reset();

    cycle(1, 0, 3'b000, 0, 0, 0);
    chk("first_addr", imem_addr, RST_PC);
    chk("first_req", imem_req, 1);
    cycle(1, 0, 3'b000, 0, 0, 0);
    chk("seq_ins0", ins_out, 32'h0); chk("seq_pc0", pc_out, 32'h4); chk("seq_addr4", imem_addr, 32'h4);
    cycle(1, 0, 3'b000, 0, 0, 0);
    chk("seq_ins4", ins_out, 32'h4); chk("seq_pc8", pc_out, 32'h8); chk("seq_addr8", imem_addr, 32'h8);

    repeat (3) begin
      cycle(0, 0, 3'b000, 0, 0, 0);
      chk("wait_addr", imem_addr, 32'h8); chk("wait_ins", ins_out, NOP); chk("wait_vld", valid_out, 0);
    end
    cycle(1, 0, 3'b000, 0, 0, 0);
    chk("wait_done_ins", ins_out, 32'h8); chk("wait_done_pc", pc_out, 32'hC);

    repeat (2) begin
      cycle(1, 1, 3'b000, 0, 0, 0);
      chk("stall_req", imem_req, 0); chk("stall_ins", ins_out, 32'h8); chk("stall_vld", valid_out, 1);
    end
    cycle(1, 0, 3'b000, 0, 0, 0);
    chk("skid_ins", ins_out, 32'hC); chk("skid_pc", pc_out, 32'h10); chk("skid_addr", imem_addr, 32'h10);

    cycle(1, 0, 3'b101, 32'h200, 32'h0, 32'h100);
    chk("jr_addr", imem_addr, 32'h100); chk("jr_ins", ins_out, NOP); chk("jr_vld", valid_out, 0);

    cycle(1, 0, 3'b001, 32'h20, 0, 0);
    chk("br_addr", imem_addr, 32'h20);
    cycle(0, 0, 3'b010, 0, 32'h40, 0);
    chk("kill_hold_addr", imem_addr, 32'h20); chk("kill_ins", ins_out, NOP);
    cycle(1, 0, 3'b000, 0, 0, 0);
    chk("kill_drop_vld", valid_out, 0); chk("kill_new_addr", imem_addr, 32'h40);
    cycle(1, 0, 3'b000, 0, 0, 0);
    chk("kill_tgt_ins", ins_out, 32'h40); chk("kill_tgt_pc", pc_out, 32'h44);

    cycle(1, 0, 3'b100, 0, 0, 32'hFFFF_FFFF);
    chk("align_addr", imem_addr, 32'hFFFF_FFFC);
    cycle(1, 0, 3'b000, 0, 0, 0);
    chk("wrap_ins", ins_out, 32'hFFFF_FFFC); chk("wrap_pc", pc_out, 32'h0); chk("wrap_addr", imem_addr, 32'h0);

    cycle(0, 0, 3'b000, 0, 0, 0);
    do_reset();
    cycle(1, 0, 3'b000, 0, 0, 0);
    chk("rerun_addr", imem_addr, RST_PC);

    xmask = $urandom;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 699) == 0) begin
        do_reset();
      end else begin
        rdy = ($urandom_range(0, 9) < 7);
        st  = ($urandom_range(0, 9) < 2);
        jon = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        br  = $urandom;
        j   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        jr  = $urandom;
        cycle(rdy, st, jon, br, j, jr);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
